// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} after WIDTH iterations. Handles signed and
// unsigned operands, divide-by-zero and mid-operation annulment.
// Optional macro DIV_EARLY_EXIT_EN: finish in one edge when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  if (WIDTH < 4) begin : g_width_chk
    $error("div_unit: WIDTH must be at least 4");
  end

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             neg_quo_q, neg_rem_q;
  logic             busy_q, ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_ext, diff;
  logic [WIDTH-1:0] rem_d, quo_d, rem_fix, quo_fix;

  // Operand magnitudes and one restoring step on the current partial state.
  // rem_ext keeps the bit shifted out of rem so divisors >= 2^(WIDTH-1) work.
  always_comb begin
    abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    rem_ext = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_ext - {1'b0, dvsr_q};
    rem_d   = diff[WIDTH] ? rem_ext[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
  end

  // Control FSM with registered busy/ready/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= S_BYZERO;
              busy_q  <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
            end else if (abs_a < abs_b) begin
              // Quotient is zero and the remainder is the dividend itself.
              state_q  <= S_END;
              ready_q  <= 1'b1;
              result_q <= {opdata1_i, {WIDTH{1'b0}}};
`endif
            end else begin
              state_q   <= S_ON;
              busy_q    <= 1'b1;
              quo_q     <= abs_a;
              dvsr_q    <= abs_b;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        S_BYZERO: begin
          state_q  <= S_END;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          result_q <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            state_q <= S_FREE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_q  <= S_END;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
              result_q <= {rem_fix, quo_fix};
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state_q <= S_FREE;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table, multi-cycle corner sequences and randomized
// divides against an arithmetic reference model (64-bit signed integer math).
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, signed_div_i, start_i, annul_i;
  logic [W-1:0] opdata1_i, opdata2_i;
  logic         busy_o, ready_o;
  logic [2*W-1:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] last_exp;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sg;
    logic [31:0] a, b, q, r;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating division: quotient rounds toward zero, remainder takes the
  // dividend's sign; 64-bit math avoids overflow on most-negative / -1.
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] mag(input bit sg, input logic [31:0] x);
    return (sg && x[31]) ? 32'(-x) : x;
  endfunction

  function automatic int exp_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (mag(sg, a) < mag(sg, b)) return 1;
`endif
    return W + 1;
  endfunction

  // Start a divide, scramble operands after acceptance, wait for ready,
  // hold start for 'hold' extra cycles, then release and check return to idle.
  task automatic run_div(input string name, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold);
    int  lat;
    bit  busy_ok, hold_ok;
    lat = 0; busy_ok = 1; hold_ok = 1;
    @(negedge clk);
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    while (!ready_o && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!ready_o && !busy_o) busy_ok = 0;
      if (lat == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      end
    end
    check({name, " ready"}, 64'(ready_o), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat(sg, a, b)));
    check({name, " result"}, result_o, exp);
    check({name, " busy_at_ready"}, 64'(busy_o), 64'd0);
    check({name, " busy_while_wait"}, 64'(busy_ok), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!ready_o || result_o !== exp) hold_ok = 0;
    end
    if (hold > 0) check({name, " hold"}, 64'(hold_ok), 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    check({name, " release_ready"}, 64'(ready_o), 64'd0);
    check({name, " release_busy"}, 64'(busy_o), 64'd0);
    last_exp = exp;
  endtask

  initial begin
    bit          sg, idle_ok;
    logic [31:0] a, b;

    tbl[0] = '{0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002};
    tbl[1] = '{1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[2] = '{1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    tbl[3] = '{0, 32'h00001234,   32'd0,        32'h00000000, 32'h00000000};
    tbl[4] = '{0, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 32'h0000000F};
    tbl[5] = '{0, 32'd3,          32'd9,        32'h00000000, 32'h00000003};
    tbl[6] = '{0, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[7] = '{1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    tbl[8] = '{1, 32'hFFFFFFF8,   32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFE};
    tbl[9] = '{0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h00000000};

    rst = 1'b1; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_div($sformatf("tbl%0d", i), tbl[i].sg, tbl[i].a, tbl[i].b,
              {tbl[i].r, tbl[i].q}, i % 3);

    // start together with annul in FREE is ignored
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1; idle_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (busy_o || ready_o) idle_ok = 0;
    end
    check("start_with_annul idle", 64'(idle_ok), 64'd1);
    start_i = 1'b0; annul_i = 1'b0;

    // annul during ON: back to FREE, result unchanged, no ready
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(negedge clk);
    check("annul pre busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul busy", 64'(busy_o), 64'd0);
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result kept", result_o, last_exp);
    idle_ok = 1;
    repeat (W + 4) begin
      @(negedge clk);
      if (ready_o || busy_o) idle_ok = 0;
    end
    check("annul no ready", 64'(idle_ok), 64'd1);
    run_div("post_annul", 0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 0);

    // synchronous reset in the middle of ON
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF00; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    run_div("post_rst", 0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    // randomized divides against the reference model
    for (int i = 0; i < 150; i++) begin
      sg = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1, 2: b = $urandom_range(1, 15);
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), sg, a, b, model(sg, a, b), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
